// File: rtl/tag_demux8_pkg.sv
// Shared types and constants for the tagged 8-lane demultiplexer.
// Holds the default sizes, the lane-state type and the drop-counter limits.
package tag_demux8_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int LANES_DEF  = 8;
   localparam int DROP_CNT_W = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

   typedef enum logic {
      LANE_EMPTY = 1'b0,
      LANE_FULL  = 1'b1
   } lane_state_e;

   // A tag is legal only when exactly one lane is selected.
   function automatic logic is_onehot(input logic [LANES_DEF-1:0] tag);
      return (tag != '0) && ((tag & (tag - 1'b1)) == '0);
   endfunction

endpackage

// File: rtl/tag_demux8_if.sv
// Source-side and lane-side handshake bundle of the tagged demultiplexer.
// The master drives offered words and lane readiness; the slave is the demux.
interface tag_demux8_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 8
);
   logic             io_in_valid;
   logic             io_in_ready;
   logic [WIDTH-1:0] io_in_data;
   logic [LANES-1:0] io_in_tag;
   logic [LANES-1:0] io_out_valid;
   logic [LANES-1:0] io_out_ready;
   logic [WIDTH-1:0] io_out_data [LANES];

   modport master (
      output io_in_valid, io_in_data, io_in_tag, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_data
   );

   modport slave (
      input  io_in_valid, io_in_data, io_in_tag, io_out_ready,
      output io_in_ready, io_out_valid, io_out_data
   );
endinterface

// File: rtl/demux_lane_slot.sv
// One-entry lane buffer: EMPTY/FULL state plus the held word.
// Flush empties the slot and wins over a same-cycle load or drain.
module demux_lane_slot
   import tag_demux8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_load,
   input  logic             i_drain,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   lane_state_e      r_state;
   lane_state_e      w_state_nxt;
   logic [WIDTH-1:0] r_data;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) r_state <= LANE_EMPTY;
      else        r_state <= w_state_nxt;
   end

   // NOTE: the default assignment first keeps this process free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      if (i_flush)                            w_state_nxt = LANE_EMPTY;
      else if (i_load)                        w_state_nxt = LANE_FULL;
      else if (r_state == LANE_FULL && i_drain) w_state_nxt = LANE_EMPTY;
   end

   always_comb begin
      o_valid = (r_state == LANE_FULL);
   end

   // NOTE: the data word is reset too, because the visible lane output must read 0 after reset.
   always_ff @(posedge clock) begin
      if (!reset)                  r_data <= '0;
      else if (i_load && !i_flush) r_data <= i_data;
   end

   assign o_data = r_data;

endmodule

// File: rtl/tag_demux8.sv
// Tagged 1-to-8 demultiplexer: routes one-hot-tagged words into one-entry lanes,
// dropping illegal tags with a sticky error flag and a saturating drop count.
module tag_demux8
   import tag_demux8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int LANES = LANES_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   tag_demux8_if.slave           bus,
   input  logic                  io_flush,
   output logic                  io_err,
   output logic [DROP_CNT_W-1:0] io_drop_cnt
);

   logic                  w_tag_legal;
   logic [LANES-1:0]      w_lane_free;
   logic                  w_sel_free;
   logic                  w_in_ready;
   logic                  w_xfer;
   logic [LANES-1:0]      w_load;
   logic                  r_err;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   assign w_tag_legal = is_onehot(bus.io_in_tag);
   assign w_lane_free = ~bus.io_out_valid | bus.io_out_ready;
   assign w_sel_free  = |(bus.io_in_tag & w_lane_free);

   // Illegal tags are always taken so a malformed word can never stall the source.
   always_comb begin
      w_in_ready = 1'b0;
      if (reset && !io_flush) w_in_ready = w_tag_legal ? w_sel_free : 1'b1;
   end

   assign bus.io_in_ready = w_in_ready;
   assign w_xfer          = bus.io_in_valid && w_in_ready;
   assign w_load          = (w_xfer && w_tag_legal) ? bus.io_in_tag : '0;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      demux_lane_slot #(.WIDTH(WIDTH)) u_slot (
         .clock   (clock),
         .reset   (reset),
         .i_flush (io_flush),
         .i_load  (w_load[g]),
         .i_drain (bus.io_out_ready[g]),
         .i_data  (bus.io_in_data),
         .o_valid (bus.io_out_valid[g]),
         .o_data  (bus.io_out_data[g])
      );
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_err      <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_xfer && !w_tag_legal) begin
         r_err <= 1'b1;
         if (r_drop_cnt != DROP_CNT_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign io_err      = r_err;
   assign io_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_tag_demux8.sv
// Self-checking bench for tag_demux8: directed scenarios followed by random traffic,
// all compared against a lane-array reference model.
module tb_tag_demux8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       err;
   logic [7:0] drop_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: which lanes hold a word, what they hold, and the drop bookkeeping.
   bit          m_full [8];
   logic [31:0] m_data [8];
   bit          m_err;
   int          m_cnt;

   tag_demux8_if #(.WIDTH(32), .LANES(8)) bus ();

   tag_demux8 #(.WIDTH(32), .LANES(8)) dut (
      .clock       (clk),
      .reset       (rst_n),
      .bus         (bus),
      .io_flush    (flush),
      .io_err      (err),
      .io_drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input logic [7:0] t,
                        input logic [7:0] ordy, input bit fl, input bit rs);
      bus.io_in_valid  = v;
      bus.io_in_data   = d;
      bus.io_in_tag    = t;
      bus.io_out_ready = ordy;
      flush            = fl;
      rst_n            = rs;
   endtask

   function automatic bit model_ready();
      if (!rst_n) return 1'b0;
      if (flush) return 1'b0;
      if ($countones(bus.io_in_tag) != 1) return 1'b1;
      for (int k = 0; k < 8; k++)
         if (bus.io_in_tag[k]) return !m_full[k] || bus.io_out_ready[k];
      return 1'b0;
   endfunction

   task automatic model_edge(input bit acc);
      bit legal;
      legal = ($countones(bus.io_in_tag) == 1);
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
         end
         m_err = 1'b0;
         m_cnt = 0;
      end else if (flush) begin
         for (int k = 0; k < 8; k++) m_full[k] = 1'b0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            if (acc && legal && bus.io_in_tag[k]) begin
               m_full[k] = 1'b1;
               m_data[k] = bus.io_in_data;
            end else if (m_full[k] && bus.io_out_ready[k]) begin
               m_full[k] = 1'b0;
            end
         end
         if (acc && !legal) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
   endtask

   // One clock: check ready before the edge, advance the model, check lanes after it.
   task automatic cycle(input string name);
      bit exp_rdy;
      @(negedge clk);
      exp_rdy = model_ready();
      check({name, " in_ready"}, bus.io_in_ready, exp_rdy);
      @(posedge clk);
      model_edge(bus.io_in_valid && exp_rdy);
      #1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("%s valid%0d", name, k), bus.io_out_valid[k], m_full[k]);
         if (m_full[k]) check($sformatf("%s data%0d", name, k), bus.io_out_data[k], m_data[k]);
      end
      check({name, " err"}, err, m_err);
      check({name, " drop_cnt"}, drop_cnt, m_cnt);
   endtask

   task automatic check_all_data_zero(input string name);
      for (int k = 0; k < 8; k++)
         check($sformatf("%s zero data%0d", name, k), bus.io_out_data[k], 32'h0);
   endtask

   initial begin
      logic [7:0] t;
      for (int k = 0; k < 8; k++) begin
         m_full[k] = 1'b0;
         m_data[k] = '0;
      end
      m_err = 1'b0;
      m_cnt = 0;

      // Reset, with a word offered that must not be taken.
      drive(1'b1, 32'h1234_5678, 8'h01, 8'h00, 1'b0, 1'b0);
      cycle("reset0");
      cycle("reset1");
      check_all_data_zero("reset");

      // Basic route into lane 2.
      drive(1'b1, 32'hDEAD_BEEF, 8'h04, 8'h00, 1'b0, 1'b1);
      cycle("route");
      check("route lane2 data", bus.io_out_data[2], 32'hDEAD_BEEF);
      check("route lane2 valid", bus.io_out_valid, 8'h04);
      drive(1'b0, 32'h0, 8'h00, 8'h04, 1'b0, 1'b1);
      cycle("route drain");

      // Backpressure on lane 5, then release by a same-cycle drain.
      drive(1'b1, 32'h5555_0001, 8'h20, 8'h00, 1'b0, 1'b1);
      cycle("bp load");
      drive(1'b1, 32'h5555_0002, 8'h20, 8'h00, 1'b0, 1'b1);
      cycle("bp stall");
      check("bp held data", bus.io_out_data[5], 32'h5555_0001);
      drive(1'b1, 32'h5555_0002, 8'h20, 8'h20, 1'b0, 1'b1);
      cycle("bp release");
      check("bp new data", bus.io_out_data[5], 32'h5555_0002);
      check("bp lane5 valid", bus.io_out_valid[5], 1'b1);

      // Illegal tags are taken and dropped; lane 5 stays FULL.
      drive(1'b1, 32'hBAD0_0000, 8'h00, 8'h00, 1'b0, 1'b1);
      cycle("illegal zero");
      drive(1'b1, 32'hBAD0_0003, 8'h03, 8'h00, 1'b0, 1'b1);
      cycle("illegal multi");
      check("illegal err", err, 1'b1);
      check("illegal cnt", drop_cnt, 8'd2);
      check("illegal lanes", bus.io_out_valid, 8'h20);

      // Saturation of the drop counter.
      for (int i = 0; i < 300; i++) begin
         t = (i % 2 == 0) ? 8'h00 : (8'h03 << (i % 7));
         drive(1'b1, $urandom, t, 8'h00, 1'b0, 1'b1);
         cycle("saturate");
      end
      check("sat cnt", drop_cnt, 8'd255);
      check("sat err", err, 1'b1);

      // Flush with lanes 0, 3, 7 FULL and a word offered to lane 1.
      drive(1'b1, 32'hA000_0000, 8'h01, 8'h00, 1'b0, 1'b1);
      cycle("fl load0");
      drive(1'b1, 32'hA000_0003, 8'h08, 8'h00, 1'b0, 1'b1);
      cycle("fl load3");
      drive(1'b1, 32'hA000_0007, 8'h80, 8'h00, 1'b0, 1'b1);
      cycle("fl load7");
      drive(1'b1, 32'hA000_0001, 8'h02, 8'h00, 1'b1, 1'b1);
      cycle("flush");
      check("flush all invalid", bus.io_out_valid, 8'h00);
      check("flush keeps cnt", drop_cnt, 8'd255);

      // Reset mid-stream.
      drive(1'b1, 32'hC000_0004, 8'h10, 8'h00, 1'b0, 1'b1);
      cycle("mid load4");
      drive(1'b1, 32'hC000_0006, 8'h40, 8'h00, 1'b0, 1'b0);
      cycle("mid reset");
      check("mid reset valid", bus.io_out_valid, 8'h00);
      check("mid reset err", err, 1'b0);
      check("mid reset cnt", drop_cnt, 8'd0);
      check_all_data_zero("mid reset");
      drive(1'b0, 32'h0, 8'h00, 8'h00, 1'b0, 1'b1);
      cycle("post reset");

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) t = 8'($urandom);
         else                        t = 8'h01 << $urandom_range(7);
         drive(1'($urandom), $urandom, t, 8'($urandom),
               ($urandom_range(19) == 0), ($urandom_range(49) != 0));
         cycle("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
